// File: rtl/cache_axi_pkg.sv
// Shared AXI constants, FSM state type and sizing helper for the cache line master.
package cache_axi_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    AW_W,
    B,
    RESP
  } state_e;

  // log2 of the number of bytes in a field of the given bit width
  function automatic int unsigned clog2_bytes(input int unsigned bits);
    return $clog2(bits / 8);
  endfunction

endpackage

// File: rtl/cache_axi_line_master_if.sv
// Bundles the cache-side request/response and the AXI4 data-memory port.
interface cache_axi_line_master_if #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
);
  localparam int unsigned LINE_W = LINE_WORDS * DATA_W;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [LINE_W-1:0] req_wdata;
  logic              resp_valid;
  logic [LINE_W-1:0] resp_rdata;
  logic              resp_err;

  logic [ADDR_W-1:0] m_axi_araddr;
  logic [7:0]        m_axi_arlen;
  logic [2:0]        m_axi_arsize;
  logic [1:0]        m_axi_arburst;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [DATA_W-1:0] m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rlast;
  logic              m_axi_rvalid;
  logic              m_axi_rready;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [DATA_W-1:0] m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    input  m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    input  m_axi_wready,
    input  m_axi_bresp, m_axi_bvalid,
    output m_axi_bready
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awvalid,
    output m_axi_awready,
    input  m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wvalid,
    output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid,
    input  m_axi_bready
  );

endinterface

// File: rtl/cache_line_buffer.sv
// One cache line of words: parallel load for writeback, per-beat write for fill,
// per-beat read for the W channel.
module cache_line_buffer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_load,
  input  logic [LINE_WORDS*DATA_W-1:0]   i_load_line,
  input  logic                           i_we,
  input  logic [$clog2(LINE_WORDS)-1:0]  i_idx,
  input  logic [DATA_W-1:0]              i_wdata,
  output logic [DATA_W-1:0]              o_rdata,
  output logic [LINE_WORDS*DATA_W-1:0]   o_line
);

  logic [DATA_W-1:0] r_word [LINE_WORDS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(LINE_WORDS); i++) r_word[i] <= '0;
    end else if (i_load) begin
      for (int i = 0; i < int'(LINE_WORDS); i++) r_word[i] <= i_load_line[i*DATA_W +: DATA_W];
    end else if (i_we) begin
      r_word[i_idx] <= i_wdata;
    end
  end

  assign o_rdata = r_word[i_idx];

  always_comb begin
    o_line = '0;
    for (int i = 0; i < int'(LINE_WORDS); i++) o_line[i*DATA_W +: DATA_W] = r_word[i];
  end

endmodule

// File: rtl/cache_axi_line_master.sv
// Turns one cache line fill or writeback into a single AXI4 INCR burst and returns
// the result to the cache in one cycle.
module cache_axi_line_master
  import cache_axi_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned LINE_WORDS = 4
) (
  input logic                    clk,
  input logic                    rst,
  cache_axi_line_master_if.master bus
);

  localparam int unsigned LINE_W = LINE_WORDS * DATA_W;
  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = clog2_bytes(LINE_W);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << OFF_W) - 1);
  localparam logic [2:0]        AXI_SIZE  = 3'(clog2_bytes(DATA_W));
  localparam logic [7:0]        AXI_LEN   = 8'(LINE_WORDS - 1);

  state_e              r_state, w_state_d;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write, r_err, r_aw_done, r_w_done;
  logic [BEAT_W-1:0]   r_beat;
  logic [LINE_W-1:0]   r_rdata;

  logic w_accept, w_ar_hs, w_r_hs, w_aw_hs, w_w_hs, w_b_hs;
  logic w_last_beat, w_aw_fin, w_w_fin;
  logic [DATA_W-1:0] w_wword;
  logic [LINE_W-1:0] w_line;

  // Handshakes derived from state so they never feed back through the valid outputs.
  assign w_accept    = (r_state == IDLE) && bus.req_valid;
  assign w_ar_hs     = (r_state == AR) && bus.m_axi_arready;
  assign w_r_hs      = (r_state == R) && bus.m_axi_rvalid;
  assign w_aw_hs     = (r_state == AW_W) && !r_aw_done && bus.m_axi_awready;
  assign w_w_hs      = (r_state == AW_W) && !r_w_done && bus.m_axi_wready;
  assign w_b_hs      = (r_state == B) && bus.m_axi_bvalid;
  assign w_last_beat = (r_beat == LAST_BEAT);
  assign w_aw_fin    = r_aw_done || w_aw_hs;
  assign w_w_fin     = r_w_done || (w_w_hs && w_last_beat);

  cache_line_buffer #(
    .DATA_W     (DATA_W),
    .LINE_WORDS (LINE_WORDS)
  ) u_line_buffer (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept && bus.req_write),
    .i_load_line (bus.req_wdata),
    .i_we        (w_r_hs),
    .i_idx       (r_beat),
    .i_wdata     (bus.m_axi_rdata),
    .o_rdata     (w_wword),
    .o_line      (w_line)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_d;
  end

  always_comb begin
    w_state_d         = r_state;
    bus.req_ready     = 1'b0;
    bus.m_axi_arvalid = 1'b0;
    bus.m_axi_rready  = 1'b0;
    bus.m_axi_awvalid = 1'b0;
    bus.m_axi_wvalid  = 1'b0;
    bus.m_axi_bready  = 1'b0;
    bus.resp_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) w_state_d = bus.req_write ? AW_W : AR;
      end
      AR: begin
        bus.m_axi_arvalid = 1'b1;
        if (w_ar_hs) w_state_d = R;
      end
      R: begin
        bus.m_axi_rready = 1'b1;
        if (w_r_hs && w_last_beat) w_state_d = RESP;
      end
      AW_W: begin
        bus.m_axi_awvalid = !r_aw_done;
        bus.m_axi_wvalid  = !r_w_done;
        if (w_aw_fin && w_w_fin) w_state_d = B;
      end
      B: begin
        bus.m_axi_bready = 1'b1;
        if (w_b_hs) w_state_d = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        w_state_d      = IDLE;
      end
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_beat    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      if (w_accept) begin
        r_addr    <= bus.req_addr & LINE_MASK;
        r_write   <= bus.req_write;
        r_err     <= 1'b0;
        r_beat    <= '0;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      // rlast must appear on exactly the final beat; the burst length is ours, not the slave's
      if (w_r_hs) begin
        r_beat <= r_beat + 1'b1;
        if ((bus.m_axi_rresp != RESP_OKAY) || (bus.m_axi_rlast != w_last_beat)) r_err <= 1'b1;
      end
      if (w_aw_hs) r_aw_done <= 1'b1;
      if (w_w_hs) begin
        r_beat <= r_beat + 1'b1;
        if (w_last_beat) r_w_done <= 1'b1;
      end
      if (w_b_hs && (bus.m_axi_bresp != RESP_OKAY)) r_err <= 1'b1;
      if ((r_state == RESP) && !r_write) r_rdata <= w_line;
    end
  end

  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arlen   = AXI_LEN;
  assign bus.m_axi_arsize  = AXI_SIZE;
  assign bus.m_axi_arburst = BURST_INCR;
  assign bus.m_axi_awaddr  = r_addr;
  assign bus.m_axi_awlen   = AXI_LEN;
  assign bus.m_axi_awsize  = AXI_SIZE;
  assign bus.m_axi_awburst = BURST_INCR;
  assign bus.m_axi_wdata   = w_wword;
  assign bus.m_axi_wstrb   = '1;
  assign bus.m_axi_wlast   = w_last_beat;
  assign bus.resp_err      = r_err;
  // Fill data is visible in the response cycle and then held until the next fill completes.
  assign bus.resp_rdata    = ((r_state == RESP) && !r_write) ? w_line : r_rdata;

endmodule

// File: tb/tb_cache_axi_line_master.sv
// Scoreboard bench: randomised AXI slave memory, reference line memory, decoupled response monitor.
module tb_cache_axi_line_master;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 4;
  localparam int unsigned LINE_W = LW * DW;
  localparam int unsigned MEM_WORDS = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_axi_line_master_if #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) bus ();

  cache_axi_line_master #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit                wr;
    logic [LINE_W-1:0] data;
    bit                err;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_err = 0;
  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  logic [31:0] exp_addr = '0;
  int          max_delay = 0;
  bit          aw_after_w = 1'b0;
  int          slverr_beat = -1;
  int          rlast_beat = LW - 1;
  bit          b_err = 1'b0;

  task automatic check(input string name, input logic [LINE_W-1:0] got,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic bit rnd_ready();
    return (max_delay == 0) || ($urandom_range(0, 2) == 0);
  endfunction

  function automatic int rnd_wait();
    return (max_delay == 0) ? 0 : int'($urandom_range(0, max_delay));
  endfunction

  // Read side of the slave memory: AR accept, then LW beats with random gaps.
  initial begin : rd_slave
    bit s_ar, s_r, s_rst, active;
    logic [31:0] a;
    int beat, wt, idx;
    active = 0; beat = 0; wt = 0; idx = 0; a = '0;
    bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rdata = '0;
    bus.m_axi_rresp = '0; bus.m_axi_rlast = 1'b0;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_ar  = bus.m_axi_arvalid && bus.m_axi_arready;
      s_r   = bus.m_axi_rvalid && bus.m_axi_rready;
      if (s_ar && !s_rst) begin
        check("araddr", LINE_W'(bus.m_axi_araddr), LINE_W'(exp_addr));
        check("arlen", LINE_W'(bus.m_axi_arlen), LINE_W'(LW - 1));
        check("arsize", LINE_W'(bus.m_axi_arsize), LINE_W'(2));
        check("arburst", LINE_W'(bus.m_axi_arburst), LINE_W'(1));
        a = bus.m_axi_araddr;
      end
      @(posedge clk); #1;
      if (s_rst) begin
        active = 0; bus.m_axi_arready = 1'b0; bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0;
        continue;
      end
      if (s_ar) begin
        active = 1; beat = 0; wt = rnd_wait();
        idx = int'((a >> 2) % MEM_WORDS);
      end
      if (s_r) begin
        bus.m_axi_rvalid = 1'b0; bus.m_axi_rlast = 1'b0; beat++;
        if (beat == int'(LW)) active = 0;
        else wt = rnd_wait();
      end
      if (active && !bus.m_axi_rvalid) begin
        if (wt == 0) begin
          bus.m_axi_rvalid = 1'b1;
          bus.m_axi_rdata  = mem[idx + beat];
          bus.m_axi_rresp  = (beat == slverr_beat) ? cache_axi_pkg::RESP_SLVERR
                                                   : cache_axi_pkg::RESP_OKAY;
          bus.m_axi_rlast  = (beat == rlast_beat);
        end else wt--;
      end
      bus.m_axi_arready = !active && rnd_ready();
    end
  end

  // Write side: AW and W accepted independently, B once both are complete.
  initial begin : wr_slave
    bit s_aw, s_w, s_b, s_rst, aw_got, armed;
    logic [31:0] a, wd;
    logic [31:0] wbuf [LW];
    int wbeat, bwt, aidx;
    aw_got = 0; armed = 0; wbeat = 0; bwt = 0; aidx = 0; a = '0; wd = '0;
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bvalid = 1'b0;
    bus.m_axi_bresp = '0;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_aw  = bus.m_axi_awvalid && bus.m_axi_awready;
      s_w   = bus.m_axi_wvalid && bus.m_axi_wready;
      s_b   = bus.m_axi_bvalid && bus.m_axi_bready;
      if (s_aw && !s_rst) begin
        check("awaddr", LINE_W'(bus.m_axi_awaddr), LINE_W'(exp_addr));
        check("awlen", LINE_W'(bus.m_axi_awlen), LINE_W'(LW - 1));
        check("awsize", LINE_W'(bus.m_axi_awsize), LINE_W'(2));
        check("awburst", LINE_W'(bus.m_axi_awburst), LINE_W'(1));
        a = bus.m_axi_awaddr;
      end
      if (s_w && !s_rst) begin
        check("wlast", LINE_W'(bus.m_axi_wlast), LINE_W'(wbeat == int'(LW) - 1));
        check("wstrb", LINE_W'(bus.m_axi_wstrb), LINE_W'(4'hF));
        wd = bus.m_axi_wdata;
      end
      @(posedge clk); #1;
      if (s_rst) begin
        aw_got = 0; armed = 0; wbeat = 0;
        bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0; bus.m_axi_bvalid = 1'b0;
        continue;
      end
      if (s_aw) begin aw_got = 1; aidx = int'((a >> 2) % MEM_WORDS); end
      if (s_w) begin wbuf[wbeat] = wd; wbeat++; end
      if (s_b) begin
        bus.m_axi_bvalid = 1'b0; aw_got = 0; wbeat = 0; armed = 0;
      end else if (aw_got && wbeat == int'(LW) && !armed) begin
        armed = 1; bwt = rnd_wait();
      end
      if (armed && !bus.m_axi_bvalid) begin
        if (bwt == 0) begin
          for (int i = 0; i < int'(LW); i++) mem[aidx + i] = wbuf[i];
          bus.m_axi_bvalid = 1'b1;
          bus.m_axi_bresp  = !b_err ? cache_axi_pkg::RESP_OKAY :
                             ($urandom_range(0, 1) == 1) ? cache_axi_pkg::RESP_SLVERR
                                                         : cache_axi_pkg::RESP_DECERR;
        end else bwt--;
      end
      bus.m_axi_awready = !aw_got && (!aw_after_w || wbeat == int'(LW)) && rnd_ready();
      bus.m_axi_wready  = (wbeat < int'(LW)) && rnd_ready();
    end
  end

  // Response monitor: every resp_valid pulse must match the oldest outstanding expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL resp_unexpected: got resp_valid 1 expected none, err %0d", bus.resp_err);
        end else begin
          e = exp_q.pop_front();
          check("resp_err", LINE_W'(bus.resp_err), LINE_W'(e.err));
          if (!e.wr) check("resp_rdata", bus.resp_rdata, e.data);
        end
      end
    end
  end

  task automatic issue(input bit wr, input logic [31:0] addr, input logic [LINE_W-1:0] wdata,
                       input bit exact_lat);
    exp_t e;
    logic [31:0] base;
    int widx, lat;
    bit got, bad;
    base = addr & 32'hFFFF_FFF0;
    widx = int'((base >> 2) % MEM_WORDS);
    e.wr = wr;
    e.data = '0;
    if (wr) begin
      e.err = b_err;
      for (int i = 0; i < int'(LW); i++) ref_mem[widx + i] = wdata[i*DW +: DW];
    end else begin
      e.err = (slverr_beat >= 0 && slverr_beat < int'(LW)) || (rlast_beat != int'(LW) - 1);
      for (int i = 0; i < int'(LW); i++) e.data[i*DW +: DW] = ref_mem[widx + i];
    end
    exp_addr = base;
    exp_q.push_back(e);
    @(negedge clk);
    check("req_ready_idle", LINE_W'(bus.req_ready), LINE_W'(1));
    bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = addr; bus.req_wdata = wdata;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    got = 0; bad = 0; lat = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (bus.resp_valid) begin got = 1; lat = k; break; end
      if (bus.req_ready) bad = 1;
    end
    check("resp_timeout", LINE_W'(got), LINE_W'(1));
    check("req_ready_busy", LINE_W'(bad), LINE_W'(0));
    if (exact_lat) check("latency", LINE_W'(lat), LINE_W'(LW + 2));
    else check("latency_min", LINE_W'(lat >= int'(LW) + 2), LINE_W'(1));
    @(negedge clk);
    check("resp_one_pulse", LINE_W'({bus.resp_valid, bus.req_ready}), LINE_W'(2'b01));
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, LINE_W'({bus.m_axi_arvalid, bus.m_axi_rready, bus.m_axi_awvalid,
                         bus.m_axi_wvalid, bus.m_axi_bready, bus.resp_valid, bus.req_ready}),
          LINE_W'(7'b0000001));
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [LINE_W-1:0] wb;
    logic [31:0] w;
    int cnt, bad;
    bit found, seen;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < int'(MEM_WORDS); i++) begin
      w = $urandom; mem[i] = w; ref_mem[i] = w;
    end
    mem[0] = 32'h1111_1111; mem[1] = 32'h1010_1010; mem[2] = '0; mem[3] = '0;
    for (int i = 0; i < 4; i++) ref_mem[i] = mem[i];

    repeat (3) @(negedge clk);
    check_idle_outputs("reset_outputs");
    check("reset_rdata", bus.resp_rdata, '0);
    check("reset_err", LINE_W'(bus.resp_err), '0);
    #1 rst = 1'b0;

    // Zero-wait fill of the line holding 0x04
    issue(1'b0, 32'h04, '0, 1'b1);
    // Writeback of 0x7C, then backdoor read of the slave memory
    wb = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    issue(1'b1, 32'h7C, wb, 1'b0);
    for (int i = 0; i < 4; i++) check("backdoor_wb", LINE_W'(mem[28 + i]), wb[i*DW +: DW]);

    // Random gaps, AW granted only after all W beats
    max_delay = 5; aw_after_w = 1'b1;
    issue(1'b1, 32'h74, wb, 1'b0);
    issue(1'b0, 32'h70, '0, 1'b0);
    issue(1'b0, 32'h04, '0, 1'b0);

    // SLVERR on beat 2, then a clean request
    max_delay = 0; aw_after_w = 1'b0;
    slverr_beat = 2;
    issue(1'b0, 32'h00, '0, 1'b1);
    slverr_beat = -1;
    issue(1'b0, 32'h40, '0, 1'b1);

    // Early rlast, then a clean request
    rlast_beat = 1;
    issue(1'b0, 32'h88, '0, 1'b1);
    rlast_beat = LW - 1;
    issue(1'b0, 32'h88, '0, 1'b1);

    // Reset during the second R beat
    exp_addr = 32'h20;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 32'h28;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    cnt = 0; found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.m_axi_rvalid && bus.m_axi_rready) cnt++;
      if (cnt == 2) begin found = 1; break; end
    end
    check("reset_reach_beat", LINE_W'(found), LINE_W'(1));
    #1 rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("midburst_reset_outputs");
    #1 rst = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.resp_valid) seen = 1;
    end
    check("no_resp_after_reset", LINE_W'(seen), '0);
    issue(1'b0, 32'h00, '0, 1'b1);

    // Randomised mix of fills and writebacks with occasional error injection
    for (int t = 0; t < 40; t++) begin
      max_delay   = int'($urandom_range(0, 5));
      aw_after_w  = ($urandom_range(0, 1) == 1);
      slverr_beat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
      rlast_beat  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LW - 2)) : int'(LW) - 1;
      b_err       = ($urandom_range(0, 5) == 0);
      wb = {$urandom, $urandom, $urandom, $urandom};
      issue($urandom_range(0, 1) == 1, $urandom_range(0, MEM_WORDS * 4 - 1), wb, 1'b0);
    end

    repeat (5) @(negedge clk);
    bad = 0;
    for (int i = 0; i < int'(MEM_WORDS); i++) if (mem[i] !== ref_mem[i]) bad++;
    check("backdoor_all", LINE_W'(bad), '0);
    check("scoreboard_drained", LINE_W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
